uart_string_tx: RTL and testbench

Parametrised UART string transmitter: next generation of the fixed-string sender. Holds a writable character buffer (loaded at run time instead of a hard-coded string) and includes its own bit serializer. On a start edge it transmits `len` characters as 8N1-style frames with configurable data bits, parity, stop bits and inter-character gap. Supports single-shot, continuous-repeat and clean abort. Sits between the board control logic (button/host loader) and the `uart_tx` pin.

---
 rtl/uart_string_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_string_tx.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_string_tx.sv
// UART string transmitter with a writable character buffer,
// built-in serializer, repeat mode and frame-boundary abort.
module uart_string_tx #(
  parameter int CYCLES_PER_BIT = 10416,
  parameter int MAX_LEN        = 16,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1,
  parameter int GAP_BITS       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic [$clog2(MAX_LEN):0]   len,
  input  logic                       start,
  input  logic                       repeat_mode,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(MAX_LEN)-1:0] char_idx,
  output logic                       uart_tx
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int NW = 16;

  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [NW-1:0] DB_LAST  = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] SB_LAST  = NW'(STOP_BITS - 1);
  localparam logic [NW-1:0] GB_LAST  = NW'(GAP_BITS - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, DATA, PARITY, STOP, GAP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [NW-1:0]        nb, nb_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par, par_n;
  logic [AW-1:0]        idx_n;
  logic [LW-1:0]        len_q, len_n, len_c;
  logic                 busy_n, done_n, tx_n;
  logic                 ab, ab_n;
  logic                 start_q, rise_q;
  logic                 bit_end, frame_end, last;
  logic [7:0]           rd;
  logic [7:0]           mem [MAX_LEN];

  // No reset: buffer contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      start_q <= start;
      rise_q  <= start & ~start_q & ~busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      nb       <= '0;
      sh       <= '0;
      par      <= 1'b0;
      char_idx <= '0;
      len_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ab       <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      nb       <= nb_n;
      sh       <= sh_n;
      par      <= par_n;
      char_idx <= idx_n;
      len_q    <= len_n;
      busy     <= busy_n;
      done     <= done_n;
      ab       <= ab_n;
      uart_tx  <= tx_n;
    end
  end

  assign len_c   = (len > LEN_MAX) ? LEN_MAX : len;
  assign bit_end = (cnt == CNT_LAST);
  assign last    = ({1'b0, char_idx} == len_q - 1'b1);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    nb_n      = nb;
    sh_n      = sh;
    par_n     = par;
    idx_n     = char_idx;
    len_n     = len_q;
    busy_n    = busy;
    done_n    = 1'b0;
    ab_n      = ab | (busy & abort);
    frame_end = 1'b0;
    rd        = mem[char_idx];
    tx_n      = 1'b1;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        ab_n  = 1'b0;
        if (rise_q) begin
          len_n = len_c;
          if (len_c == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = LOAD;
            busy_n  = 1'b1;
            idx_n   = '0;
          end
        end
      end
      LOAD: begin
        sh_n    = rd[DATA_BITS-1:0];
        par_n   = (^sh_n) ^ 1'(PARITY_ODD);
        state_n = START;
        cnt_n   = '0;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          nb_n    = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (nb == DB_LAST) begin
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
            nb_n    = '0;
          end else begin
            nb_n = nb + 1'b1;
            sh_n = sh >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
          nb_n    = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (nb == SB_LAST) begin
            nb_n = '0;
            if (GAP_BITS > 0) state_n = GAP;
            else frame_end = 1'b1;
          end else begin
            nb_n = nb + 1'b1;
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (nb == GB_LAST) begin
            nb_n      = '0;
            frame_end = 1'b1;
          end else begin
            nb_n = nb + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Pass ends on abort or last char; repeat restarts without idling.
    if (frame_end) begin
      ab_n = 1'b0;
      if (ab | abort) begin
        done_n  = 1'b1;
        idx_n   = '0;
        state_n = IDLE;
        busy_n  = 1'b0;
      end else if (last) begin
        done_n = 1'b1;
        idx_n  = '0;
        if (repeat_mode) begin
          state_n = LOAD;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end else begin
        idx_n   = char_idx + 1'b1;
        state_n = LOAD;
      end
    end

    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_string_tx.sv
// Bench for uart_string_tx: two configurations, per-cycle line,
// busy and done checked against a frame-level reference model.
module tb_uart_string_tx;

  localparam int CPB = 4;
  localparam int DB_A = 8, PE_A = 0, PO_A = 0, SB_A = 1, GB_A = 0;
  localparam int DB_B = 7, PE_B = 1, PO_B = 1, SB_B = 2, GB_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en_a = 0, start_a = 0, repeat_a = 0, abort_a = 0;
  logic [3:0] wr_addr_a = '0;
  logic [7:0] wr_data_a = '0;
  logic [4:0] len_a = '0;
  logic       busy_a, done_a, tx_a;
  logic [3:0] idx_a;

  logic       wr_en_b = 0, start_b = 0, repeat_b = 0, abort_b = 0;
  logic [1:0] wr_addr_b = '0;
  logic [7:0] wr_data_b = '0;
  logic [2:0] len_b = '0;
  logic       busy_b, done_b, tx_b;
  logic [1:0] idx_b;

  uart_string_tx #(
    .CYCLES_PER_BIT(CPB), .MAX_LEN(16), .DATA_BITS(DB_A),
    .PARITY_EN(PE_A), .PARITY_ODD(PO_A),
    .STOP_BITS(SB_A), .GAP_BITS(GB_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .len(len_a),
    .start(start_a), .repeat_mode(repeat_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .char_idx(idx_a),
    .uart_tx(tx_a)
  );

  uart_string_tx #(
    .CYCLES_PER_BIT(CPB), .MAX_LEN(4), .DATA_BITS(DB_B),
    .PARITY_EN(PE_B), .PARITY_ODD(PO_B),
    .STOP_BITS(SB_B), .GAP_BITS(GB_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .len(len_b),
    .start(start_b), .repeat_mode(repeat_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .char_idx(idx_b),
    .uart_tx(tx_b)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } smp_t;

  smp_t       exp_q[$];
  bit         pend_done;
  logic       obs_tx[$];
  logic [3:0] obs_idx[$];
  logic [7:0] sh_a [16];
  int r_err, r_done, r_busy, r_first;

  // Reference model: expected per-cycle samples, one per clock.
  function automatic void push(input logic tx, input logic bz);
    smp_t s;
    s.tx = tx;
    s.busy = bz;
    s.done = pend_done;
    pend_done = 1'b0;
    exp_q.push_back(s);
  endfunction

  function automatic void add_frame(input bit sel, input logic [7:0] ch);
    int db, pe, sb, gb;
    logic p;
    db = sel ? DB_B : DB_A;
    pe = sel ? PE_B : PE_A;
    sb = sel ? SB_B : SB_A;
    gb = sel ? GB_B : GB_A;
    p = sel ? 1'(PO_B) : 1'(PO_A);
    push(1'b1, 1'b1);
    repeat (CPB) push(1'b0, 1'b1);
    for (int i = 0; i < db; i++) begin
      repeat (CPB) push(ch[i], 1'b1);
      p ^= ch[i];
    end
    if (pe != 0) repeat (CPB) push(p, 1'b1);
    repeat ((sb + gb) * CPB) push(1'b1, 1'b1);
  endfunction

  function automatic void end_pass(input bit more);
    pend_done = 1'b1;
    if (!more) push(1'b1, 1'b0);
  endfunction

  function automatic void begin_model();
    exp_q.delete();
    pend_done = 1'b0;
    push(1'b1, 1'b0);
  endfunction

  task automatic wr(input bit sel, input int a, input logic [7:0] d);
    if (sel) begin
      wr_en_b = 1; wr_addr_b = 2'(a); wr_data_b = d;
    end else begin
      wr_en_a = 1; wr_addr_a = 4'(a); wr_data_a = d;
    end
    @(negedge clk);
    wr_en_a = 0;
    wr_en_b = 0;
  endtask

  // Launch a pass and sample every cycle against exp_q.
  task automatic run(input bit sel, input int ab_at, input int rp_at,
                     input int rs_at, input int wr_at, input int wa,
                     input logic [7:0] wd);
    logic tx, bz, dn, st;
    logic [3:0] ix;
    r_err = 0; r_done = 0; r_busy = 0; r_first = -1;
    obs_tx.delete();
    obs_idx.delete();
    st = 1'b1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tx = sel ? tx_b : tx_a;
      bz = sel ? busy_b : busy_a;
      dn = sel ? done_b : done_a;
      ix = sel ? {2'b00, idx_b} : idx_a;
      obs_tx.push_back(tx);
      obs_idx.push_back(ix);
      if ({tx, bz, dn} !== exp_q[i]) begin
        if (r_err == 0) r_first = i;
        r_err++;
      end
      if (dn === 1'b1) r_done++;
      if (bz === 1'b1) r_busy++;
      if (i == 1 || i == rs_at + 3) st = 1'b0;
      if (i == rs_at) st = 1'b1;
      if (sel) begin
        start_b = st;
        abort_b = (i == ab_at);
        if (i == rp_at) repeat_b = 1'b0;
        wr_en_b = (i == wr_at);
        wr_addr_b = 2'(wa);
        wr_data_b = wd;
      end else begin
        start_a = st;
        abort_a = (i == ab_at);
        if (i == rp_at) repeat_a = 1'b0;
        wr_en_a = (i == wr_at);
        wr_addr_a = 4'(wa);
        wr_data_a = wd;
      end
    end
    start_a = 0; abort_a = 0; wr_en_a = 0;
    start_b = 0; abort_b = 0; wr_en_b = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tx_a !== 1'b1) begin
      bad++; $display("FAIL rst_tx_a got=%b want=1", tx_a);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL rst_busy_a got=%b want=0", busy_a);
    end
    total++;
    if (done_a !== 1'b0) begin
      bad++; $display("FAIL rst_done_a got=%b want=0", done_a);
    end
    total++;
    if (idx_a !== 4'd0) begin
      bad++; $display("FAIL rst_idx_a got=%0d want=0", idx_a);
    end
    total++;
    if ({tx_b, busy_b, done_b, idx_b} !== 5'b10000) begin
      bad++;
      $display("FAIL rst_b got=%b want=10000",
               {tx_b, busy_b, done_b, idx_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ab();
    wr(0, 0, 8'h41); sh_a[0] = 8'h41;
    wr(0, 1, 8'h42); sh_a[1] = 8'h42;
    len_a = 5'd2;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    @(negedge clk);
    begin_model();
    add_frame(0, 8'h41);
    add_frame(0, 8'h42);
    end_pass(0);
    repeat (4) push(1'b1, 1'b0);
    run(0, -1, -1, 20, -1, 0, 8'h00);
    total++;
    if (r_err !== 0) begin
      bad++;
      $display("FAIL ab_wave errs=%0d first=%0d want 0", r_err, r_first);
    end
    total++;
    if (r_done !== 1) begin
      bad++; $display("FAIL ab_done got=%0d want=1", r_done);
    end
    total++;
    if (r_busy !== 82) begin
      bad++; $display("FAIL ab_busy got=%0d want=82", r_busy);
    end
    total++;
    if (obs_idx[10] !== 4'd0 || obs_idx[60] !== 4'd1) begin
      bad++;
      $display("FAIL ab_idx got=%0d,%0d want=0,1",
               obs_idx[10], obs_idx[60]);
    end
  endtask

  task automatic test_write_busy();
    logic [7:0] nv;
    for (int i = 0; i < 3; i++) begin
      sh_a[i] = 8'($urandom);
      wr(0, i, sh_a[i]);
    end
    nv = 8'($urandom);
    len_a = 5'd3;
    begin_model();
    add_frame(0, sh_a[0]);
    add_frame(0, sh_a[1]);
    add_frame(0, nv);
    end_pass(0);
    repeat (2) push(1'b1, 1'b0);
    run(0, -1, -1, -1, 10, 2, nv);
    sh_a[2] = nv;
    total++;
    if (r_err !== 0) begin
      bad++;
      $display("FAIL wr_new errs=%0d first=%0d want 0", r_err, r_first);
    end
    nv = ~sh_a[1];
    len_a = 5'd2;
    begin_model();
    add_frame(0, sh_a[0]);
    add_frame(0, sh_a[1]);
    end_pass(0);
    repeat (2) push(1'b1, 1'b0);
    run(0, -1, -1, -1, 42, 1, nv);
    sh_a[1] = nv;
    total++;
    if (r_err !== 0) begin
      bad++;
      $display("FAIL wr_same errs=%0d first=%0d want 0", r_err, r_first);
    end
  endtask

  task automatic test_repeat();
    len_a = 5'd3;
    repeat_a = 1'b1;
    begin_model();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 3; c++) add_frame(0, sh_a[c]);
      end_pass(p < 2);
    end
    repeat (3) push(1'b1, 1'b0);
    run(0, -1, 300, -1, -1, 0, 8'h00);
    total++;
    if (r_err !== 0) begin
      bad++;
      $display("FAIL rep_wave errs=%0d first=%0d want 0", r_err, r_first);
    end
    total++;
    if (r_done !== 3) begin
      bad++; $display("FAIL rep_done got=%0d want=3", r_done);
    end
    total++;
    if (r_busy !== 369) begin
      bad++; $display("FAIL rep_busy got=%0d want=369", r_busy);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) begin
      sh_a[i] = 8'($urandom);
      wr(0, i, sh_a[i]);
    end
    len_a = 5'd5;
    begin_model();
    add_frame(0, sh_a[0]);
    add_frame(0, sh_a[1]);
    end_pass(0);
    repeat (8) push(1'b1, 1'b0);
    run(0, 55, -1, -1, -1, 0, 8'h00);
    total++;
    if (r_err !== 0) begin
      bad++;
      $display("FAIL abort_wave errs=%0d first=%0d want 0", r_err, r_first);
    end
    total++;
    if (r_done !== 1) begin
      bad++; $display("FAIL abort_done got=%0d want=1", r_done);
    end
    total++;
    if (idx_a !== 4'd0) begin
      bad++; $display("FAIL abort_idx got=%0d want=0", idx_a);
    end
  endtask

  task automatic test_len_edges();
    len_a = 5'd0;
    begin_model();
    end_pass(0);
    repeat (3) push(1'b1, 1'b0);
    run(0, -1, -1, -1, -1, 0, 8'h00);
    total++;
    if (r_err !== 0) begin
      bad++;
      $display("FAIL len0_wave errs=%0d first=%0d want 0", r_err, r_first);
    end
    total++;
    if (r_done !== 1 || r_busy !== 0) begin
      bad++;
      $display("FAIL len0_flags done=%0d busy=%0d want 1,0",
               r_done, r_busy);
    end
    for (int i = 0; i < 16; i++) begin
      sh_a[i] = 8'($urandom);
      wr(0, i, sh_a[i]);
    end
    len_a = 5'd20;
    begin_model();
    for (int i = 0; i < 16; i++) add_frame(0, sh_a[i]);
    end_pass(0);
    repeat (3) push(1'b1, 1'b0);
    run(0, -1, -1, -1, -1, 0, 8'h00);
    total++;
    if (r_err !== 0) begin
      bad++;
      $display("FAIL len20_wave errs=%0d first=%0d want 0", r_err, r_first);
    end
    total++;
    if (r_busy !== 16 * 41) begin
      bad++; $display("FAIL len20_busy got=%0d want=%0d", r_busy, 16 * 41);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        sh_a[i] = 8'($urandom);
        wr(0, i, sh_a[i]);
      end
      len_a = 5'(n);
      begin_model();
      for (int i = 0; i < n; i++) add_frame(0, sh_a[i]);
      end_pass(0);
      repeat (2) push(1'b1, 1'b0);
      run(0, -1, -1, $urandom_range(5, 35), -1, 0, 8'h00);
      total++;
      if (r_err !== 0 || r_done !== 1) begin
        bad++;
        $display("FAIL rand%0d errs=%0d first=%0d done=%0d want 0,1",
                 it, r_err, r_first, r_done);
      end
    end
  endtask

  task automatic test_parity_b();
    logic [7:0] c [4];
    int hi;
    c[0] = 8'h03;
    for (int i = 1; i < 4; i++) c[i] = 8'($urandom) | 8'h80;
    for (int i = 0; i < 4; i++) wr(1, i, c[i]);
    len_b = 3'd7;
    begin_model();
    for (int i = 0; i < 4; i++) add_frame(1, c[i]);
    end_pass(0);
    repeat (3) push(1'b1, 1'b0);
    run(1, -1, -1, -1, -1, 0, 8'h00);
    total++;
    if (r_err !== 0 || r_done !== 1) begin
      bad++;
      $display("FAIL b_wave errs=%0d first=%0d done=%0d want 0,1",
               r_err, r_first, r_done);
    end
    total++;
    if (obs_tx[34] !== 1'b1) begin
      bad++; $display("FAIL b_parity got=%b want=1", obs_tx[34]);
    end
    hi = 0;
    for (int i = 38; i < 60; i++) begin
      if (obs_tx[i] !== 1'b1) break;
      hi++;
    end
    total++;
    if (hi !== (SB_B + GB_B) * CPB + 1) begin
      bad++;
      $display("FAIL b_high got=%0d want=%0d", hi, (SB_B + GB_B) * CPB + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    len_a = 5'd2;
    start_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) start_a = 1'b0;
      if (tx_a === 1'b0) begin
        seen = 1;
        break;
      end
    end
    start_a = 1'b0;
    total++;
    if (!seen) begin
      bad++; $display("FAIL mid_start got=no_start_bit want=start_bit");
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst tx=%b busy=%b want 1,0", tx_a, busy_a);
    end
    total++;
    if (done_a !== 1'b0 || idx_a !== 4'd0) begin
      bad++;
      $display("FAIL mid_rst_st done=%b idx=%0d want 0,0", done_a, idx_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ab();
    test_write_busy();
    test_repeat();
    test_abort();
    test_len_edges();
    test_random();
    test_parity_b();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
